// File: rtl/i2c_target.sv
// i2c_target: I2C bus target with 7-bit address, byte write strobe and read-byte request handshake.
// SCL/SDA are oversampled on clk; SDA is open-drain (driven low or released).
module i2c_target #(
  parameter logic [6:0] I2C_SLAVE_ADDR = 7'd52
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK} state_t;
  state_t      state;
  logic [1:0]  scl_s, sda_s;
  logic        scl_d, sda_d;
  logic [6:0]  sr;
  logic [7:0]  tx;
  logic [3:0]  cnt;
  logic        rw, sda_oe;
  logic        scl, sda, scl_rise, scl_fall, sda_rise, sda_fall, start, stop;

  assign i2c_sda  = sda_oe ? 1'b0 : 1'bz;
  assign scl      = scl_s[1];
  assign sda      = sda_s[1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign sda_rise = sda & ~sda_d;
  assign sda_fall = ~sda & sda_d;
  assign start    = sda_fall & scl;
  assign stop     = sda_rise & scl;

  // Preset to 1 so an idle bus never looks like START/STOP when reset lifts
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], i2c_scl};
      sda_s <= {sda_s[0], i2c_sda};
      scl_d <= scl;
      sda_d <= sda;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state    <= IDLE;
      sda_oe   <= 1'b0;
      wr_data  <= 8'h00;
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      busy     <= 1'b0;
      cnt      <= 4'd0;
      sr       <= 7'd0;
      tx       <= 8'h00;
      rw       <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      if (rd_req) tx <= rd_data;
      if (start) begin
        state  <= ADDR;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (stop) begin
        state  <= IDLE;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            sr  <= {sr[5:0], sda};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt   <= 4'd0;
              state <= (sr == I2C_SLAVE_ADDR) ? ADDR_ACK : IDLE;
              if (sr == I2C_SLAVE_ADDR) begin
                rw     <= sda;
                rd_req <= sda;
                busy   <= 1'b1;
              end
            end
          end
          // First fall after the byte starts the ACK, the second one ends it
          ADDR_ACK, WR_ACK: if (scl_fall) begin
            if (!sda_oe) sda_oe <= 1'b1;
            else if (state == WR_ACK || !rw) begin
              sda_oe <= 1'b0;
              state  <= WR_DATA;
            end else begin
              sda_oe <= ~tx[7];
              tx     <= {tx[6:0], 1'b0};
              cnt    <= 4'd1;
              state  <= RD_DATA;
            end
          end
          WR_DATA: if (scl_rise) begin
            sr  <= {sr[5:0], sda};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt      <= 4'd0;
              wr_data  <= {sr, sda};
              wr_valid <= 1'b1;
              state    <= WR_ACK;
            end
          end
          RD_DATA: if (scl_fall) begin
            sda_oe <= (cnt == 4'd8) ? 1'b0 : ~tx[7];
            cnt    <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
            state  <= (cnt == 4'd8) ? RD_ACK : RD_DATA;
            if (cnt != 4'd8) tx <= {tx[6:0], 1'b0};
          end
          // cnt=0: waiting for the controller's ACK bit, cnt=1: ACKed, next byte on the fall
          RD_ACK: if (scl_rise && cnt == 4'd0) begin
            if (!sda) begin
              rd_req <= 1'b1;
              cnt    <= 4'd1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (scl_fall && cnt == 4'd1) begin
            sda_oe <= ~tx[7];
            tx     <= {tx[6:0], 1'b0};
            state  <= RD_DATA;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: randomized I2C controller driving i2c_target, checked against a transaction-level model.
module tb_i2c_target;
  localparam logic [6:0] ADDR = 7'd52;
  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] wr_data;
  logic       wr_valid, rd_req, busy;
  wire        sda_bus;
  int         n_cmp = 0, n_bad = 0, hp = 8;
  int         n_wr = 0, rd_cnt = 0, rd_idx = 0;
  logic       rd_adv = 1'b0, drv_seen = 1'b0;
  logic       prev_dl = 1'b0, prev_wv = 1'b0, prev_scl = 1'b1;
  logic [7:0] wr_src[$], rd_src[$], exp_wr[$];

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;

  i2c_target #(.I2C_SLAVE_ADDR(ADDR)) dut (
    .clk(clk), .areset_n(areset_n), .i2c_scl(scl), .i2c_sda(sda_bus),
    .wr_data(wr_data), .wr_valid(wr_valid), .rd_req(rd_req), .rd_data(rd_data), .busy(busy)
  );

  function void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endfunction

  // Per-cycle checker, sampled 2 time units after the rising edge
  always begin
    logic dl;
    @(posedge clk);
    #2;
    dl = (sda_bus === 1'b0) && !m_low;
    if (areset_n) begin
      if (dl) drv_seen = 1'b1;
      if (scl && prev_scl) check("sda_stable_scl_high", dl, prev_dl);
      if (wr_valid) begin
        n_wr++;
        check("wr_valid_width", prev_wv, 1'b0);
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wr_unexpected: wr_valid=1 data=%02h, required no pulse", wr_data);
        end else check("wr_data", wr_data, exp_wr.pop_front());
      end
      if (rd_req) rd_cnt++;
    end
    prev_dl = dl;
    prev_wv = wr_valid;
    prev_scl = scl;
    if (rd_adv) rd_idx++;
    rd_adv = rd_req;
    rd_data = (rd_idx < rd_src.size()) ? rd_src[rd_idx] : 8'h00;
  end

  task automatic wt(); repeat (hp) @(negedge clk); endtask
  task automatic half(); repeat (hp / 2) @(negedge clk); endtask

  task automatic bstart();
    if (!scl) begin
      half(); m_low = 1'b0; half(); scl = 1'b1; wt();
    end
    m_low = 1'b1; wt(); scl = 1'b0;
  endtask

  task automatic bstop();
    half(); m_low = 1'b1; half(); scl = 1'b1; wt(); m_low = 1'b0; wt();
  endtask

  task automatic bbit(input logic b, output logic r);
    half(); m_low = ~b; half(); scl = 1'b1; half(); r = sda_bus; half(); scl = 1'b0;
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bbit(b[i], r);
    bbit(1'b1, ack);
  endtask

  task automatic rbyte(input logic ackb, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bbit(1'b1, r);
      d[i] = r;
    end
    bbit(ackb, r);
  endtask

  task automatic write_txn(input logic [7:0] ab, input int n, input bit do_stop);
    logic ack, match;
    bstart();
    drv_seen = 1'b0;
    match = (ab[7:1] == ADDR) && !ab[0];
    wbyte(ab, ack);
    check("wr_addr_ack", ack, !match);
    check("wr_busy", busy, match);
    for (int i = 0; i < n; i++) begin
      if (match) exp_wr.push_back(wr_src[i]);
      wbyte(wr_src[i], ack);
      check("wr_byte_ack", ack, !match);
    end
    if (do_stop) begin
      bstop(); wt();
      check("wr_busy_after_stop", busy, 1'b0);
    end
    check("wr_all_seen", exp_wr.size(), 0);
    if (!match) check("miss_no_drive", drv_seen, 1'b0);
  endtask

  task automatic read_txn(input int n);
    logic ack;
    logic [7:0] d;
    rd_idx = 0; rd_adv = 1'b0; rd_cnt = 0;
    bstart();
    wbyte({ADDR, 1'b1}, ack);
    check("rd_addr_ack", ack, 1'b0);
    check("rd_busy", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      rbyte(i == n - 1, d);
      check("rd_byte", d, rd_src[i]);
    end
    check("rd_released_after_nack", sda_bus, 1'b1);
    bstop(); wt();
    check("rd_req_count", rd_cnt, n);
    check("rd_busy_after_stop", busy, 1'b0);
  endtask

  task automatic abort_txn(input int k);
    logic ack, r;
    bstart();
    wbyte({ADDR, 1'b0}, ack);
    check("abort_addr_ack", ack, 1'b0);
    for (int i = 0; i < k; i++) bbit(1'($urandom), r);
    bstop(); wt();
    check("abort_busy", busy, 1'b0);
    check("abort_no_wr", exp_wr.size(), 0);
  endtask

  initial begin
    int w0, n, k;
    logic [6:0] a;
    logic r;
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sda", sda_bus, 1'b1);
    @(negedge clk);
    areset_n = 1'b1;
    wt();
    // Directed write: 0x68, A5, 3C
    w0 = n_wr;
    wr_src = '{8'hA5, 8'h3C};
    write_txn(8'h68, 2, 1);
    check("dir_wr_count", n_wr - w0, 2);
    check("dir_wr_last", wr_data, 8'h3C);
    // Address miss
    w0 = n_wr;
    wr_src = '{8'hFF};
    write_txn(8'h6A, 1, 1);
    check("dir_miss_no_wr", n_wr - w0, 0);
    // Read two bytes, ACK then NACK
    rd_src = '{8'h5A, 8'hC3};
    read_txn(2);
    // Write then repeated START into a read
    w0 = n_wr;
    wr_src = '{8'h01};
    write_txn(8'h68, 1, 0);
    rd_src = '{8'h96};
    read_txn(1);
    check("rs_wr_count", n_wr - w0, 1);
    check("rs_wr_data", wr_data, 8'h01);
    // Reset while the target is driving the address ACK
    bstart();
    for (int i = 7; i >= 0; i--) bbit(k_bit(8'h68, i), r);
    half(); m_low = 1'b0;
    repeat (2) @(negedge clk);
    check("ack_driven_before_rst", sda_bus, 1'b0);
    areset_n = 1'b0;
    #1;
    check("rst_mid_ack_sda", sda_bus, 1'b1);
    check("rst_mid_ack_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    wt(); scl = 1'b1; wt();
    wr_src = '{8'h5E, 8'h81};
    write_txn(8'h68, 2, 1);
    // STOP after 4 data bits, then a normal write
    abort_txn(4);
    wr_src = '{8'h42};
    write_txn(8'h68, 1, 1);
    for (int t = 0; t < 14; t++) begin
      hp = $urandom_range(8, 14);
      n = $urandom_range(1, 4);
      k = $urandom_range(0, 3);
      wr_src = {};
      rd_src = {};
      for (int i = 0; i < n; i++) begin
        wr_src.push_back(8'($urandom));
        rd_src.push_back(8'($urandom));
      end
      if (k == 0) write_txn({ADDR, 1'b0}, n, 1);
      else if (k == 1) read_txn(n);
      else if (k == 2) begin
        a = 7'($urandom_range(0, 127));
        if (a == ADDR) a = a + 7'd1;
        write_txn({a, 1'($urandom)}, n, 1);
      end else abort_txn($urandom_range(1, 7));
    end
    wt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic logic k_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction
endmodule
